// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, memory width codes, FSM states.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WA_BYTE = 2'd0;
  localparam logic [1:0] WA_HALF = 2'd1;
  localparam logic [1:0] WA_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Request payload latched at acceptance.
  typedef struct packed {
    logic            we;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // Access size in bytes from funct3[1:0]; illegal 11 maps to 4 and is rejected elsewhere.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Memory width code for an access size.
  function automatic logic [1:0] wa_of(input logic [2:0] size);
    case (size)
      3'd1:    return WA_BYTE;
      3'd2:    return WA_HALF;
      default: return WA_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extension: selects byte/half/word from an LSB-aligned raw word and extends it.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] result
);

  // Sign- or zero-extend according to the load flavour.
  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{24{raw[7]}}, raw[7:0]};
      F3_H:    result = {{16{raw[15]}}, raw[15:0]};
      F3_W:    result = raw;
      F3_BU:   result = {24'd0, raw[7:0]};
      F3_HU:   result = {16'd0, raw[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: one request at a time, range/alignment checking, byte-splitting of
// misaligned accesses, registered memory port and registered response.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES        = 1024,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [1:0]      mem_wa,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  state_t          state_q, state_d;
  lsu_req_t        req_q, in_req, cur;
  logic [2:0]      size_q, in_size, cur_size;
  logic            split_q, in_split, cur_split;
  logic [1:0]      k_q, k_d, last_k;
  logic [XLEN-1:0] buf_q, raw_c, asm_c, ext;
  logic            f3_ok, oor, misal, bad, accept;
  logic [XLEN-1:0] wsel;

  logic            mem_we_d, resp_valid_d, resp_err_d;
  logic [1:0]      mem_wa_d;
  logic [XLEN-1:0] mem_addr_d, mem_wdata_d, resp_rdata_d;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && (state_q == ST_IDLE);
  assign last_k    = 2'(size_q - 3'd1);

  // Decode and check the incoming request; address range uses 33 bits so wrap is caught.
  always_comb begin
    in_req  = {req_we, req_funct3, req_addr, req_wdata};
    in_size = size_of(req_funct3);
    if (req_we) begin
      f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    end else begin
      f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
              (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
    end
    oor      = ({1'b0, req_addr} + 33'(in_size) - 33'd1) >= 33'(MEM_BYTES);
    misal    = (req_addr & 32'(in_size - 3'd1)) != 32'd0;
    bad      = !f3_ok || oor || (misal && !SPLIT_MISALIGNED);
    in_split = misal && SPLIT_MISALIGNED;
  end

  // Request view used to precompute next memory outputs: incoming in IDLE, latched otherwise.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur       = in_req;
      cur_size  = in_size;
      cur_split = in_split;
    end else begin
      cur       = req_q;
      cur_size  = size_q;
      cur_split = split_q;
    end
  end

  // Merge the byte fetched this cycle into the split-load buffer.
  always_comb begin
    raw_c                      = buf_q;
    raw_c[{k_q, 3'b000} +: 8]  = mem_rdata[7:0];
    asm_c                      = split_q ? raw_c : mem_rdata;
  end

  lsu_load_ext u_load_ext (
    .funct3 (req_q.funct3),
    .raw    (asm_c),
    .result (ext)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and byte counter.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          k_d     = 2'd0;
          state_d = bad ? ST_RESP : ST_ACC;
        end
      end
      ST_ACC: begin
        if (split_q && (k_q != last_k)) k_d = k_q + 2'd1;
        else                            state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: next values of the registered memory port and response.
  always_comb begin
    mem_addr_d   = '0;
    mem_we_d     = 1'b0;
    mem_wa_d     = WA_BYTE;
    mem_wdata_d  = '0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    wsel         = cur.wdata >> {k_d, 3'b000};
    if (state_d == ST_ACC) begin
      mem_addr_d = cur.addr + 32'(k_d);
      mem_we_d   = cur.we;
      if (cur_split) begin
        mem_wa_d    = WA_BYTE;
        mem_wdata_d = cur.we ? {24'd0, wsel[7:0]} : '0;
      end else begin
        mem_wa_d    = wa_of(cur_size);
        mem_wdata_d = cur.we ? cur.wdata : '0;
      end
    end
    if (state_d == ST_RESP) begin
      resp_valid_d = 1'b1;
      if (state_q == ST_IDLE) resp_err_d = 1'b1;
      else if (!req_q.we)     resp_rdata_d = ext;
    end
  end

  // Request latch, byte counter and split-load buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      size_q  <= '0;
      split_q <= 1'b0;
      k_q     <= '0;
      buf_q   <= '0;
    end else begin
      k_q <= k_d;
      if (accept) begin
        req_q   <= in_req;
        size_q  <= in_size;
        split_q <= in_split;
        buf_q   <= '0;
      end else if ((state_q == ST_ACC) && split_q && !req_q.we) begin
        buf_q <= raw_c;
      end
    end
  end

  // Registered memory port and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wa     <= WA_BYTE;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      mem_addr   <= mem_addr_d;
      mem_we     <= mem_we_d;
      mem_wa     <= mem_wa_d;
      mem_wdata  <= mem_wdata_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
    end
  end

endmodule
